// File: rtl/dct8_chen_stream_if.sv
`timescale 1ns/1ps
// dct8_chen_stream_if: row-stream handshake bundle for the 8-point DCT engine
interface dct8_chen_stream_if #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 18,
    parameter int TAG_W  = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [7:0][DATA_W-1:0] x;
    logic [TAG_W-1:0]       in_tag;
    logic                   out_valid;
    logic                   out_ready;
    logic [7:0][OUT_W-1:0]  y;
    logic [TAG_W-1:0]       out_tag;
    logic                   out_sat;
    modport master (output in_valid, x, in_tag, out_ready, input in_ready, out_valid, y, out_tag, out_sat);
    modport slave  (input in_valid, x, in_tag, out_ready, output in_ready, out_valid, y, out_tag, out_sat);
endinterface

// File: rtl/dct8_chen_stream.sv
`timescale 1ns/1ps
// dct8_chen_stream: 4-stage pipelined 8-point DCT-II (Chen) with valid/ready, tag, saturation stats
module dct8_chen_stream #(
    parameter int DATA_W  = 16,
    parameter int CONST_W = 16,
    parameter int OUT_W   = 18,
    parameter int TAG_W   = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    dct8_chen_stream_if.slave  bus,
    output logic [CNT_W-1:0]   sat_count
);
    localparam int  A_W   = DATA_W + 1;
    localparam int  B_W   = DATA_W + 2;
    localparam int  P_W   = B_W + CONST_W;
    localparam int  S_W   = P_W + 2;
    localparam int  SH    = CONST_W - 1;
    localparam real SCALE = real'(64'd1 << (CONST_W - 2));
    localparam logic signed [CONST_W-1:0] C1 = CONST_W'(int'(0.98078528040323 * SCALE));
    localparam logic signed [CONST_W-1:0] C2 = CONST_W'(int'(0.92387953251129 * SCALE));
    localparam logic signed [CONST_W-1:0] C3 = CONST_W'(int'(0.83146961230255 * SCALE));
    localparam logic signed [CONST_W-1:0] C4 = CONST_W'(int'(0.70710678118655 * SCALE));
    localparam logic signed [CONST_W-1:0] C5 = CONST_W'(int'(0.55557023301960 * SCALE));
    localparam logic signed [CONST_W-1:0] C6 = CONST_W'(int'(0.38268343236509 * SCALE));
    localparam logic signed [CONST_W-1:0] C7 = CONST_W'(int'(0.19509032201613 * SCALE));
    localparam logic signed [S_W-1:0] RND  = S_W'(64'd1 << (CONST_W - 2));
    localparam logic signed [S_W-1:0] MAXV = S_W'((64'd1 << (OUT_W - 1)) - 64'd1);
    localparam logic signed [S_W-1:0] MINV = ~MAXV;

    logic                  adv, v1, v2, v3;
    logic [TAG_W-1:0]      t1, t2, t3;
    logic signed [A_W-1:0] a  [4];
    logic signed [A_W-1:0] d1 [4];
    logic signed [B_W-1:0] b  [4];
    logic signed [A_W-1:0] d2 [4];
    logic signed [P_W-1:0] pe [6];
    logic signed [P_W-1:0] po [4][4];
    logic signed [S_W-1:0] s  [8];
    logic signed [S_W-1:0] r  [8];
    logic [7:0][OUT_W-1:0] yc;
    logic [7:0]            clip;

    function automatic logic signed [P_W-1:0] mul(input logic signed [P_W-1:0] v, input logic signed [CONST_W-1:0] c);
        return v * P_W'(c);
    endfunction

    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    // S1: mirrored-sample sums feed the even half, differences feed the odd half
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            v1 <= 1'b0;
            t1 <= '0;
            for (int n = 0; n < 4; n++) begin
                a[n]  <= '0;
                d1[n] <= '0;
            end
        end else if (adv) begin
            v1 <= bus.in_valid;
            t1 <= bus.in_tag;
            for (int n = 0; n < 4; n++) begin
                a[n]  <= A_W'($signed(bus.x[n])) + A_W'($signed(bus.x[7-n]));
                d1[n] <= A_W'($signed(bus.x[n])) - A_W'($signed(bus.x[7-n]));
            end
        end

    // S2: second even butterfly; odd differences ride along unchanged
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            v2 <= 1'b0;
            t2 <= '0;
            for (int n = 0; n < 4; n++) begin
                b[n]  <= '0;
                d2[n] <= '0;
            end
        end else if (adv) begin
            v2   <= v1;
            t2   <= t1;
            b[0] <= B_W'(a[0]) + B_W'(a[3]);
            b[1] <= B_W'(a[1]) + B_W'(a[2]);
            b[2] <= B_W'(a[0]) - B_W'(a[3]);
            b[3] <= B_W'(a[1]) - B_W'(a[2]);
            d2   <= d1;
        end

    // S3: full-width constant products; po[n][j] is d[n] times c(2j+1)
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            v3 <= 1'b0;
            t3 <= '0;
            for (int n = 0; n < 6; n++) pe[n] <= '0;
            for (int n = 0; n < 4; n++)
                for (int j = 0; j < 4; j++) po[n][j] <= '0;
        end else if (adv) begin
            v3    <= v2;
            t3    <= t2;
            pe[0] <= mul(P_W'(b[0]), C4);
            pe[1] <= mul(P_W'(b[1]), C4);
            pe[2] <= mul(P_W'(b[2]), C2);
            pe[3] <= mul(P_W'(b[2]), C6);
            pe[4] <= mul(P_W'(b[3]), C2);
            pe[5] <= mul(P_W'(b[3]), C6);
            for (int n = 0; n < 4; n++) begin
                po[n][0] <= mul(P_W'(d2[n]), C1);
                po[n][1] <= mul(P_W'(d2[n]), C3);
                po[n][2] <= mul(P_W'(d2[n]), C5);
                po[n][3] <= mul(P_W'(d2[n]), C7);
            end
        end

    // S4 combinational part: product sums, round half up, clip to the output range
    always_comb begin
        s[0] = S_W'(pe[0]) + S_W'(pe[1]);
        s[4] = S_W'(pe[0]) - S_W'(pe[1]);
        s[2] = S_W'(pe[2]) + S_W'(pe[5]);
        s[6] = S_W'(pe[3]) - S_W'(pe[4]);
        s[1] = S_W'(po[0][0]) + S_W'(po[1][1]) + S_W'(po[2][2]) + S_W'(po[3][3]);
        s[3] = S_W'(po[0][1]) - S_W'(po[1][3]) - S_W'(po[2][0]) - S_W'(po[3][2]);
        s[5] = S_W'(po[0][2]) - S_W'(po[1][0]) + S_W'(po[2][3]) + S_W'(po[3][1]);
        s[7] = S_W'(po[0][3]) - S_W'(po[1][2]) + S_W'(po[2][1]) - S_W'(po[3][0]);
        for (int k = 0; k < 8; k++) begin
            r[k]    = (s[k] + RND) >>> SH;
            clip[k] = (r[k] > MAXV) || (r[k] < MINV);
            yc[k]   = (r[k] > MAXV) ? MAXV[OUT_W-1:0] : (r[k] < MINV) ? MINV[OUT_W-1:0] : r[k][OUT_W-1:0];
        end
    end

    // S4 register: output row, held while downstream stalls
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.y         <= '0;
            bus.out_tag   <= '0;
            bus.out_sat   <= 1'b0;
        end else if (adv) begin
            bus.out_valid <= v3;
            bus.y         <= yc;
            bus.out_tag   <= t3;
            bus.out_sat   <= v3 && (|clip);
        end

    // Count delivered rows that were clipped, sticking at all-ones
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            sat_count <= '0;
        else if (bus.out_valid && bus.out_ready && bus.out_sat && !(&sat_count))
            sat_count <= sat_count + CNT_W'(1);
endmodule

// File: tb/tb_dct8_chen_stream.sv
`timescale 1ns/1ps
// tb_dct8_chen_stream: directed checks for the pipelined 8-point DCT row engine
module tb_dct8_chen_stream;
    localparam real PI = 3.14159265358979;
    typedef logic [7:0][15:0] row_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cnt0, cnt1;
    int          checks = 0;
    int          errors = 0;
    row_t        rows [16];

    always #5 clk = ~clk;

    dct8_chen_stream_if #(.DATA_W(16), .OUT_W(18), .TAG_W(4)) b0 ();
    dct8_chen_stream_if #(.DATA_W(16), .OUT_W(16), .TAG_W(4)) b1 ();

    dct8_chen_stream u0 (.clk(clk), .rst_n(rst_n), .bus(b0), .sat_count(cnt0));
    dct8_chen_stream #(.OUT_W(16)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1), .sat_count(cnt1));

    function automatic real golden(input row_t rw, input int k);
        real acc = 0.0;
        for (int n = 0; n < 8; n++) acc += real'($signed(rw[n])) * $cos((2 * n + 1) * k * PI / 16.0);
        return (k == 0) ? acc * 0.5 / $sqrt(2.0) : acc * 0.5;
    endfunction

    function automatic row_t rnd_row();
        row_t rw;
        for (int n = 0; n < 8; n++) rw[n] = 16'(int'($urandom_range(4000)) - 2000);
        return rw;
    endfunction

    task automatic push_wait(input row_t rw, input logic [3:0] tag, output int lat);
        @(negedge clk);
        b0.x = rw;
        b0.in_tag = tag;
        b0.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b0.in_valid = 1'b0;
        lat = 1;
        while (b0.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        if (b0.out_valid !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", b0.out_valid); end
        checks++; if (b0.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", b0.in_ready); end
        checks++; if (b0.y !== '0 || b0.out_tag !== 4'd0 || b0.out_sat !== 1'b0) begin errors++; $display("FAIL reset_outputs got y=%h tag=%h sat=%b want 0", b0.y, b0.out_tag, b0.out_sat); end
        checks++; if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin errors++; $display("FAIL reset_sat_count got %0d/%0d want 0/0", cnt0, cnt1); end
        rst_n = 1'b1;
        b0.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (b0.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", b0.in_ready); end
    endtask

    task automatic test_dc();
        row_t rw;
        int lat;
        for (int n = 0; n < 8; n++) rw[n] = 16'd100;
        push_wait(rw, 4'd5, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL dc_latency got %0d want 4", lat); end
        checks++; if (b0.y[0] !== 18'd283) begin errors++; $display("FAIL dc_y0 got %0d want 283", $signed(b0.y[0])); end
        for (int k = 1; k < 8; k++) begin
            checks++; if (b0.y[k] !== 18'd0) begin errors++; $display("FAIL dc_y%0d got %0d want 0", k, $signed(b0.y[k])); end
        end
        checks++; if (b0.out_tag !== 4'd5) begin errors++; $display("FAIL dc_tag got %0d want 5", b0.out_tag); end
        checks++; if (b0.out_sat !== 1'b0) begin errors++; $display("FAIL dc_sat got %b want 0", b0.out_sat); end
    endtask

    task automatic test_impulse();
        row_t rw;
        int lat;
        rw = '0;
        rw[0] = 16'd256;
        push_wait(rw, 4'd1, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL imp_latency got %0d want 4", lat); end
        checks++; if (b0.y[0] !== 18'd91) begin errors++; $display("FAIL imp_y0 got %0d want 91", $signed(b0.y[0])); end
        checks++; if (b0.y[1] !== 18'd126) begin errors++; $display("FAIL imp_y1 got %0d want 126", $signed(b0.y[1])); end
        for (int k = 2; k < 8; k++) begin
            real g, e;
            g = golden(rw, k);
            e = g - real'($signed(b0.y[k]));
            checks++; if (e > 1.0 || e < -1.0) begin errors++; $display("FAIL imp_y%0d got %0d want %f", k, $signed(b0.y[k]), g); end
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0, rcv = 0, cyc = 0;
        bit gap = 0;
        for (int i = 0; i < 16; i++) rows[i] = rnd_row();
        b0.out_ready = 1'b1;
        while (rcv < 16 && cyc < 100) begin
            @(negedge clk);
            b0.in_valid = (sent < 16);
            b0.x = rows[sent % 16];
            b0.in_tag = 4'(sent);
            #1;
            if (b0.out_valid === 1'b1) begin
                checks++; if (b0.out_tag !== 4'(rcv)) begin errors++; $display("FAIL b2b_tag got %0d want %0d", b0.out_tag, rcv); end
                for (int k = 0; k < 8; k++) begin
                    real g, e;
                    g = golden(rows[rcv], k);
                    e = g - real'($signed(b0.y[k]));
                    checks++; if (e > 1.0 || e < -1.0) begin errors++; $display("FAIL b2b_y%0d row %0d got %0d want %f", k, rcv, $signed(b0.y[k]), g); end
                end
                rcv++;
            end else if (rcv > 0) gap = 1;
            if (b0.in_valid && b0.in_ready) sent++;
            cyc++;
        end
        b0.in_valid = 1'b0;
        checks++; if (rcv !== 16) begin errors++; $display("FAIL b2b_count got %0d want 16", rcv); end
        checks++; if (gap) begin errors++; $display("FAIL b2b_gap got gap=1 want 0"); end
    endtask

    task automatic test_backpressure();
        int sent = 0, rcv = 0, cyc = 0;
        bit held = 0, extra = 0;
        logic [7:0][17:0] hy;
        logic [3:0] ht;
        for (int i = 0; i < 10; i++) rows[i] = rnd_row();
        while (rcv < 10 && cyc < 400) begin
            @(negedge clk);
            b0.out_ready = 1'($urandom_range(1));
            b0.in_valid = (sent < 10);
            b0.x = rows[sent % 10];
            b0.in_tag = 4'(sent);
            #1;
            checks++; if (b0.in_ready !== (!b0.out_valid || b0.out_ready)) begin errors++; $display("FAIL bp_in_ready got %b want %b", b0.in_ready, !b0.out_valid || b0.out_ready); end
            if (held) begin
                checks++; if (b0.out_valid !== 1'b1 || b0.y !== hy || b0.out_tag !== ht) begin errors++; $display("FAIL bp_hold got v=%b tag=%0d y=%h want v=1 tag=%0d y=%h", b0.out_valid, b0.out_tag, b0.y, ht, hy); end
            end
            held = b0.out_valid && !b0.out_ready;
            hy = b0.y;
            ht = b0.out_tag;
            if (b0.out_valid && b0.out_ready) begin
                checks++; if (b0.out_tag !== 4'(rcv)) begin errors++; $display("FAIL bp_tag got %0d want %0d", b0.out_tag, rcv); end
                for (int k = 0; k < 8; k++) begin
                    real g, e;
                    g = golden(rows[rcv], k);
                    e = g - real'($signed(b0.y[k]));
                    checks++; if (e > 1.0 || e < -1.0) begin errors++; $display("FAIL bp_y%0d row %0d got %0d want %f", k, rcv, $signed(b0.y[k]), g); end
                end
                rcv++;
            end
            if (b0.in_valid && b0.in_ready) sent++;
            cyc++;
        end
        b0.in_valid = 1'b0;
        b0.out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (b0.out_valid !== 1'b0) extra = 1;
        end
        checks++; if (rcv !== 10) begin errors++; $display("FAIL bp_count got %0d want 10", rcv); end
        checks++; if (extra) begin errors++; $display("FAIL bp_extra_row got extra=1 want 0"); end
    endtask

    task automatic test_saturation();
        row_t rw;
        int lat;
        for (int n = 0; n < 8; n++) rw[n] = 16'h7fff;
        @(negedge clk);
        b1.x = rw;
        b1.in_tag = 4'd9;
        b1.in_valid = 1'b1;
        b1.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        b1.in_valid = 1'b0;
        lat = 1;
        while (b1.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        checks++; if (lat !== 4) begin errors++; $display("FAIL sat_latency got %0d want 4", lat); end
        checks++; if (b1.y[0] !== 16'h7fff) begin errors++; $display("FAIL sat_pos_y0 got %0d want 32767", $signed(b1.y[0])); end
        checks++; if (b1.out_sat !== 1'b1) begin errors++; $display("FAIL sat_pos_flag got %b want 1", b1.out_sat); end
        checks++; if (cnt1 !== 16'd0) begin errors++; $display("FAIL sat_cnt_before got %0d want 0", cnt1); end
        b1.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (cnt1 !== 16'd1) begin errors++; $display("FAIL sat_cnt_one got %0d want 1", cnt1); end
        for (int n = 0; n < 8; n++) rw[n] = 16'h8000;
        b1.x = rw;
        b1.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b1.in_valid = 1'b0;
        lat = 1;
        while (b1.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        checks++; if (b1.y[0] !== 16'h8000) begin errors++; $display("FAIL sat_neg_y0 got %0d want -32768", $signed(b1.y[0])); end
        checks++; if (b1.out_sat !== 1'b1) begin errors++; $display("FAIL sat_neg_flag got %b want 1", b1.out_sat); end
        @(negedge clk);
        checks++; if (cnt1 !== 16'd2) begin errors++; $display("FAIL sat_cnt_two got %0d want 2", cnt1); end
        checks++; if (cnt0 !== 16'd0) begin errors++; $display("FAIL sat_cnt_wide got %0d want 0", cnt0); end
    endtask

    task automatic test_midstream_reset();
        row_t rw;
        int lat;
        bit stale = 0;
        b0.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b0.x = rnd_row();
            b0.in_tag = 4'(i);
            b0.in_valid = 1'b1;
        end
        @(negedge clk);
        b0.in_valid = 1'b0;
        checks++; if (b0.out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got %b want 1", b0.out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", b0.out_valid); end
        checks++; if (cnt1 !== 16'd0) begin errors++; $display("FAIL rst_sat_count got %0d want 0", cnt1); end
        checks++; if (b0.y !== '0 || b0.out_tag !== 4'd0) begin errors++; $display("FAIL rst_y_tag got y=%h tag=%0d want 0", b0.y, b0.out_tag); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (b0.out_valid !== 1'b0) stale = 1;
        end
        checks++; if (stale) begin errors++; $display("FAIL rst_stale_row got stale=1 want 0"); end
        for (int n = 0; n < 8; n++) rw[n] = 16'd100;
        push_wait(rw, 4'd3, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL rst_latency got %0d want 4", lat); end
        checks++; if (b0.y[0] !== 18'd283 || b0.out_tag !== 4'd3) begin errors++; $display("FAIL rst_next_row got y0=%0d tag=%0d want 283/3", $signed(b0.y[0]), b0.out_tag); end
    endtask

    initial begin
        b0.in_valid = 1'b0;
        b0.x = '0;
        b0.in_tag = '0;
        b0.out_ready = 1'b0;
        b1.in_valid = 1'b0;
        b1.x = '0;
        b1.in_tag = '0;
        b1.out_ready = 1'b1;
        test_reset();
        test_dc();
        test_impulse();
        test_back_to_back();
        test_backpressure();
        test_saturation();
        test_midstream_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
